core_data_mem_responder: RTL and testbench

- Responder end of the core's data-memory interface (write enable, byte address, write data, 4-bit write-transfer lane mask, read data).
- Provides a word-organised RAM with combinational read and synchronous byte-lane write, so the single-cycle core sees load data in the same cycle.
- Runs a post-reset clear sequencer and rejects illegal lane masks.
- Optionally decodes a small memory-mapped I/O window.
- Instantiated at top level beside the core; top level holds the core in reset until ready_o is high.

---
 rtl/core_data_mem_responder.sv | 85 ++++++++
 tb/tb_core_data_mem_responder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/core_data_mem_responder.sv
// core_data_mem_responder: word RAM with post-reset clear, byte-lane stores and lane-mask checking.
// Define DMEM_MMIO_EN to decode the top four words as cycle/GPIO/store/status registers.
module core_data_mem_responder #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4,
  parameter int DEPTH          = 2 ** (ADDR_WIDTH - 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we_i,
  input  logic [ADDR_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     val_write_i,
  input  logic [TRANSFER_WIDTH-1:0] write_transfer_i,
  output logic [DATA_WIDTH-1:0]     val_read_o,
  output logic                      ready_o,
  output logic                      err_o,
  output logic [DATA_WIDTH-1:0]     gpio_o
);
  localparam int IW = ADDR_WIDTH - 2;
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [IW-1:0] clr_idx, idx, mem_waddr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] lane_bits, ram_rd, mem_wdata, rd;
  logic legal, active, store_ok, store_bad, mem_we, in_win, unused;
  assign unused    = ^addr_i[1:0];
  assign idx       = addr_i[ADDR_WIDTH-1:2];
  assign ram_rd    = mem[idx];
  assign active    = state == READY && we_i && |write_transfer_i;
  assign legal     = write_transfer_i inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  assign store_ok  = active && legal;
  assign store_bad = active && !legal;
  for (genvar i = 0; i < TRANSFER_WIDTH; i++) begin : g_lane
    assign lane_bits[8*i +: 8] = {8{write_transfer_i[i]}};
  end
  // The clear sequencer owns the write port until READY.
  assign mem_we    = state == CLEAR || (store_ok && !in_win);
  assign mem_waddr = state == CLEAR ? clr_idx : idx;
  assign mem_wdata = state == CLEAR ? '0 : (ram_rd & ~lane_bits) | (val_write_i & lane_bits);
  always_ff @(posedge clk)
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  always_comb state_n = (state == CLEAR && clr_idx == IW'(DEPTH - 1)) ? READY : state;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
      err_o   <= 1'b0;
    end else begin
      state   <= state_n;
      clr_idx <= state == CLEAR ? clr_idx + 1'b1 : clr_idx;
      err_o   <= store_bad;
    end
  assign ready_o = state == READY;
`ifdef DMEM_MMIO_EN
  logic [DATA_WIDTH-1:0] cyc_cnt, st_cnt, gpio, mmio_rd;
  logic sticky, win_st;
  logic [1:0] sel;
  assign in_win  = &addr_i[ADDR_WIDTH-1:4];
  assign sel     = addr_i[3:2];
  assign win_st  = store_ok && in_win;
  assign mmio_rd = sel == 2'd0 ? cyc_cnt :
                   sel == 2'd1 ? gpio :
                   sel == 2'd2 ? st_cnt : DATA_WIDTH'({sticky, ready_o});
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cyc_cnt <= '0;
      st_cnt  <= '0;
      gpio    <= '0;
      sticky  <= 1'b0;
    end else begin
      if (ready_o) cyc_cnt <= cyc_cnt + 1'b1;
      if (store_ok) st_cnt <= st_cnt + 1'b1;
      if (win_st && sel == 2'd1) gpio <= (gpio & ~lane_bits) | (val_write_i & lane_bits);
      sticky <= store_bad | (sticky & !(win_st && sel == 2'd3 && write_transfer_i[0] && val_write_i[1]));
    end
  assign gpio_o = gpio;
  assign rd     = in_win ? mmio_rd : ram_rd;
`else
  assign in_win = 1'b0;
  assign gpio_o = '0;
  assign rd     = ram_rd;
`endif
  assign val_read_o = (rst || state == CLEAR) ? '0 : rd;
endmodule

// File: tb/tb_core_data_mem_responder.sv
// tb_core_data_mem_responder: scoreboard bench against a byte-level memory model.
module tb_core_data_mem_responder;
  logic clk = 1'b0, rst = 1'b1, we_i = 1'b0;
  logic [9:0] addr_i = '0;
  logic [31:0] val_write_i = '0;
  logic [3:0] write_transfer_i = '0;
  logic [31:0] val_read_o, gpio_o;
  logic ready_o, err_o;
  core_data_mem_responder dut (
    .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .val_write_i(val_write_i),
    .write_transfer_i(write_transfer_i), .val_read_o(val_read_o), .ready_o(ready_o),
    .err_o(err_o), .gpio_o(gpio_o)
  );
  always #5 clk = ~clk;
  typedef struct {string name; int kind; logic [31:0] exp;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, n;
  logic [31:0] ref_mem [256];
  logic [31:0] m_gpio = '0, m_cyc = '0, m_st = '0;
  logic m_sticky = 1'b0, pend_err = 1'b0;
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  function automatic void push(input string nm, input int k, input logic [31:0] e);
    exp_t x;
    x.name = nm; x.kind = k; x.exp = e;
    sb.push_back(x);
  endfunction
  always @(negedge clk)
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, e.kind == 0 ? val_read_o : e.kind == 1 ? {31'b0, err_o} :
                  e.kind == 2 ? gpio_o : {31'b0, ready_o}, e.exp);
    end
  function automatic logic legal(input logic [3:0] m);
    return m == 4'hF || m == 4'h3 || m == 4'hC || $countones(m) == 1;
  endfunction
  function automatic logic in_win(input logic [9:0] a);
`ifdef DMEM_MMIO_EN
    return a >= 10'h3F0;
`else
    return a > 10'h3FF;
`endif
  endfunction
  function automatic logic [31:0] model_rd(input logic [9:0] a);
    if (in_win(a))
      case (a[3:2])
        2'd0: return m_cyc;
        2'd1: return m_gpio;
        2'd2: return m_st;
        default: return {30'b0, m_sticky, 1'b1};
      endcase
    return ref_mem[a[9:2]];
  endfunction
  function automatic void model_wr(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    if (!w || m == 4'h0) return;
    if (!legal(m)) begin
      m_sticky = 1'b1;
      return;
    end
    m_st++;
    for (int b = 0; b < 4; b++)
      if (m[b]) begin
        if (!in_win(a)) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
        else if (a[3:2] == 2'd1) m_gpio[8*b +: 8] = d[8*b +: 8];
      end
    if (in_win(a) && a[3:2] == 2'd3 && m[0] && d[1]) m_sticky = 1'b0;
  endfunction
  task automatic cyc(input logic w, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    we_i = w; addr_i = a; val_write_i = d; write_transfer_i = m;
    push("read", 0, model_rd(a));
    push("err", 1, {31'b0, pend_err});
    push("gpio", 2, m_gpio);
    push("ready", 3, 32'd1);
    @(posedge clk);
    pend_err = w && m != 4'h0 && !legal(m);
    model_wr(w, a, d, m);
    m_cyc++;
    #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
  initial begin
    logic [3:0] lm [7];
    lm = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    repeat (3) @(posedge clk);
    #1 addr_i = 10'h010;
    push("rst_read", 0, 32'd0); push("rst_ready", 3, 32'd0);
    push("rst_err", 1, 32'd0); push("rst_gpio", 2, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1 push("clear_ready", 3, 32'd0); push("clear_read", 0, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (ready_o) break;
      if (n == 5) begin we_i = 1'b1; addr_i = 10'h000; val_write_i = 32'hFFFFFFFF; write_transfer_i = 4'hF; end
      if (n == 6) write_transfer_i = 4'h5;
      if (n == 7) begin we_i = 1'b0; push("clear_err", 1, 32'd0); end
      if (n == 8) push("clear_err2", 1, 32'd0);
    end
    chk("ready_latency", n, 32'd256);
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int i = 0; i < 256; i++) cyc(1'b0, 10'(i * 4 + $urandom_range(0, 3)), '0, '0);
    cyc(1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
    cyc(1'b1, 10'h010, 32'h000000AA, 4'h1);
    cyc(1'b0, 10'h010, '0, '0);
    cyc(1'b1, 10'h020, 32'h12345678, 4'hC);
    cyc(1'b0, 10'h020, '0, '0);
    cyc(1'b1, 10'h020, 32'hFFFFFFFF, 4'h0);
    cyc(1'b0, 10'h020, '0, '0);
    cyc(1'b1, 10'h030, 32'h11111111, 4'hF);
    cyc(1'b1, 10'h030, 32'hFFFFFFFF, 4'h5);
    cyc(1'b0, 10'h030, '0, '0);
    cyc(1'b0, 10'h030, '0, '0);
    cyc(1'b0, 10'h3FC, '0, '0);
    cyc(1'b1, 10'h3FC, 32'h2, 4'h1);
    cyc(1'b0, 10'h3FC, '0, '0);
    cyc(1'b1, 10'h3F4, 32'hA5A5A5A5, 4'hF);
    cyc(1'b0, 10'h3F4, '0, '0);
    cyc(1'b1, 10'h3F4, 32'hCAFEF00D, 4'hF);
    cyc(1'b0, 10'h3F4, '0, '0);
    cyc(1'b0, 10'h3F8, '0, '0);
    cyc(1'b0, 10'h3F0, '0, '0);
    repeat (9) cyc(1'b0, 10'h000, '0, '0);
    cyc(1'b0, 10'h3F0, '0, '0);
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), $urandom,
          $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : lm[$urandom_range(0, 6)]);
    for (int i = 0; i < 64; i++) cyc(1'b0, 10'($urandom_range(0, 1023)), '0, '0);
    @(negedge clk);
    #1 $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
